// File: rtl/hv_noise_pkg.sv
// Shared types and constants for the hypervector noise injector: FSM states,
// LFSR reset seed and Fibonacci tap masks for the supported LFSR widths.
package hv_noise_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StFlip = 2'd1,
    StDone = 2'd2
  } state_e;

  localparam logic [31:0] LFSR_DEFAULT = 32'h0000_ACE1;

  // Tap masks use 0-based bit positions of the 1-based polynomial taps.
  localparam logic [31:0] TAPS_16 = 32'h0000_B400;  // 16,14,13,11
  localparam logic [31:0] TAPS_24 = 32'h00E1_0000;  // 24,23,22,17
  localparam logic [31:0] TAPS_32 = 32'h8020_0003;  // 32,22,2,1

  function automatic logic [31:0] lfsr_taps(input int unsigned lw);
    case (lw)
      24:      return TAPS_24;
      32:      return TAPS_32;
      default: return TAPS_16;
    endcase
  endfunction

endpackage

// File: rtl/hv_flip_injector_if.sv
// Input/output streaming handshake bundle for hv_flip_injector.
interface hv_flip_injector_if #(
  parameter int unsigned D  = 256,
  parameter int unsigned CW = 12
) ();

  logic          in_valid;
  logic          in_ready;
  logic [D-1:0]  in_vec;
  logic [CW-1:0] flip_count;
  logic          out_valid;
  logic          out_ready;
  logic [D-1:0]  out_vec;

  modport master (
    output in_valid, in_vec, flip_count, out_ready,
    input  in_ready, out_valid, out_vec
  );

  modport slave (
    input  in_valid, in_vec, flip_count, out_ready,
    output in_ready, out_valid, out_vec
  );

endinterface

// File: rtl/hv_lfsr.sv
// Fibonacci LFSR with synchronous reset, seed load (zero seed maps to the
// default seed so the register can never lock up) and step enable.
module hv_lfsr
  import hv_noise_pkg::*;
#(
  parameter int unsigned LW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic [LW-1:0] load_val,
  input  logic          step,
  output logic [LW-1:0] state
);

  localparam logic [LW-1:0] Taps    = LW'(lfsr_taps(LW));
  localparam logic [LW-1:0] Default = LW'(LFSR_DEFAULT);

  logic [LW-1:0] lfsr_q, lfsr_d;
  logic          fb;

  always_comb begin
    fb     = ^(lfsr_q & Taps);
    lfsr_d = lfsr_q;
    if (load) begin
      lfsr_d = (load_val == '0) ? Default : load_val;
    end else if (step) begin
      lfsr_d = {lfsr_q[LW-2:0], fb};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr_q <= Default;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign state = lfsr_q;

endmodule

// File: rtl/hv_flip_injector.sv
// Applies flip_count pseudo-random bit toggles to a hypervector, one per FLIP
// cycle, rejecting LFSR indices >= D. Optional flip_mask output: HV_FLIP_MASK_EN.
module hv_flip_injector
  import hv_noise_pkg::*;
#(
  parameter int unsigned D  = 256,
  parameter int unsigned LW = 16,
  parameter int unsigned CW = 12
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          seed_load,
  input  logic [LW-1:0] seed_in,
  output logic          busy,
`ifdef HV_FLIP_MASK_EN
  output logic [D-1:0]  flip_mask,
`endif
  hv_flip_injector_if.slave bus
);

  localparam int unsigned  IW   = $clog2(D);
  localparam logic [IW:0]  DLim = D[IW:0];

  state_e        state_q, state_d;
  logic [CW-1:0] rem_q, rem_d;
  logic [D-1:0]  out_vec_q, out_vec_d;
  logic          out_valid_q, out_valid_d;
`ifdef HV_FLIP_MASK_EN
  logic [D-1:0]  mask_q, mask_d;
`endif

  logic [LW-1:0] lfsr;
  logic [IW-1:0] idx;
  logic          hit;
  logic          accept;
  logic          lfsr_load;
  logic          lfsr_step;
  logic          unused_lfsr_hi;

  assign bus.in_ready = (state_q == StIdle) && !seed_load;
  assign accept       = bus.in_valid && bus.in_ready;
  assign lfsr_load    = (state_q == StIdle) && seed_load;
  assign lfsr_step    = (state_q == StFlip);

  // Candidate index comes from the LFSR value before this cycle's step.
  assign idx            = lfsr[IW-1:0];
  assign hit            = {1'b0, idx} < DLim;
  assign unused_lfsr_hi = ^lfsr[LW-1:IW];

  hv_lfsr #(
    .LW(LW)
  ) u_lfsr (
    .clk      (clk),
    .rst      (rst),
    .load     (lfsr_load),
    .load_val (seed_in),
    .step     (lfsr_step),
    .state    (lfsr)
  );

  always_comb begin
    state_d     = state_q;
    rem_d       = rem_q;
    out_vec_d   = out_vec_q;
    out_valid_d = out_valid_q;
`ifdef HV_FLIP_MASK_EN
    mask_d      = mask_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          out_vec_d = bus.in_vec;
          rem_d     = bus.flip_count;
`ifdef HV_FLIP_MASK_EN
          mask_d    = '0;
`endif
          state_d   = (bus.flip_count != '0) ? StFlip : StDone;
        end
      end
      StFlip: begin
        if (hit) begin
          out_vec_d[idx] = ~out_vec_q[idx];
`ifdef HV_FLIP_MASK_EN
          mask_d[idx]    = ~mask_q[idx];
`endif
          rem_d          = rem_q - 1'b1;
          if (rem_q == CW'(1)) begin
            state_d = StDone;
          end
        end
      end
      StDone: begin
        // out_valid is registered, so it rises one cycle after entering DONE.
        out_valid_d = 1'b1;
        if (out_valid_q && bus.out_ready) begin
          out_valid_d = 1'b0;
          state_d     = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      rem_q       <= '0;
      out_vec_q   <= '0;
      out_valid_q <= 1'b0;
`ifdef HV_FLIP_MASK_EN
      mask_q      <= '0;
`endif
    end else begin
      state_q     <= state_d;
      rem_q       <= rem_d;
      out_vec_q   <= out_vec_d;
      out_valid_q <= out_valid_d;
`ifdef HV_FLIP_MASK_EN
      mask_q      <= mask_d;
`endif
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_vec   = out_vec_q;
  assign busy          = (state_q != StIdle);
`ifdef HV_FLIP_MASK_EN
  assign flip_mask     = mask_q;
`endif

endmodule

// File: tb/tb_hv_flip_injector.sv
// Self-checking bench for hv_flip_injector: a D=256 and a D=200 instance are
// checked against a sequential LFSR/rejection reference model.
module tb_hv_flip_injector;

  localparam logic [15:0] SeedDefault = 16'hACE1;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        seed_load_a = 1'b0;
  logic [15:0] seed_in_a = '0;
  logic        busy_a;
  logic        seed_load_b = 1'b0;
  logic [15:0] seed_in_b = '0;
  logic        busy_b;
`ifdef HV_FLIP_MASK_EN
  logic [255:0] flip_mask_a;
  logic [199:0] flip_mask_b;
`endif

  int n_checks = 0;
  int n_fails  = 0;

  logic [15:0] ms_a = SeedDefault;
  logic [15:0] ms_b = SeedDefault;

  hv_flip_injector_if #(.D(256), .CW(12)) bus_a ();
  hv_flip_injector_if #(.D(200), .CW(12)) bus_b ();

  hv_flip_injector #(.D(256), .LW(16), .CW(12)) u_dut_a (
    .clk       (clk),
    .rst       (rst),
    .seed_load (seed_load_a),
    .seed_in   (seed_in_a),
    .busy      (busy_a),
`ifdef HV_FLIP_MASK_EN
    .flip_mask (flip_mask_a),
`endif
    .bus       (bus_a)
  );

  hv_flip_injector #(.D(200), .LW(16), .CW(12)) u_dut_b (
    .clk       (clk),
    .rst       (rst),
    .seed_load (seed_load_b),
    .seed_in   (seed_in_b),
    .busy      (busy_b),
`ifdef HV_FLIP_MASK_EN
    .flip_mask (flip_mask_b),
`endif
    .bus       (bus_b)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // x^16 + x^14 + x^13 + x^11, shifting the feedback in at the bottom.
  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
  endfunction

  function automatic logic [255:0] rand256();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  // Reference: draw indices until n of them land below d; cycles include DONE entry.
  task automatic model_run(input int d, input int iw, inout logic [15:0] s,
                           input logic [255:0] v, input int n,
                           output logic [255:0] exp, output int cycles);
    int left;
    int idx;
    exp    = v;
    cycles = 0;
    left   = n;
    while (left > 0) begin
      idx = int'(s) % (1 << iw);
      if (idx < d) begin
        exp[idx] = ~exp[idx];
        left--;
      end
      cycles++;
      s = lfsr_next(s);
    end
    cycles++;
  endtask

  task automatic seed_a(input logic [15:0] val);
    seed_load_a = 1'b1;
    seed_in_a   = val;
    tick();
    seed_load_a = 1'b0;
    ms_a = (val == 16'h0) ? SeedDefault : val;
  endtask

  task automatic seed_b(input logic [15:0] val);
    seed_load_b = 1'b1;
    seed_in_b   = val;
    tick();
    seed_load_b = 1'b0;
    ms_b = (val == 16'h0) ? SeedDefault : val;
  endtask

  task automatic start_a(input logic [255:0] v, input int n, output int lat);
    bus_a.in_vec     = v;
    bus_a.flip_count = 12'(n);
    bus_a.in_valid   = 1'b1;
    tick();
    bus_a.in_valid = 1'b0;
    lat = 0;
    while (bus_a.out_valid !== 1'b1 && lat < 3000) begin
      tick();
      lat++;
    end
  endtask

  task automatic start_b(input logic [199:0] v, input int n, output int lat);
    bus_b.in_vec     = v;
    bus_b.flip_count = 12'(n);
    bus_b.in_valid   = 1'b1;
    tick();
    bus_b.in_valid = 1'b0;
    lat = 0;
    while (bus_b.out_valid !== 1'b1 && lat < 3000) begin
      tick();
      lat++;
    end
  endtask

  task automatic finish_a();
    bus_a.out_ready = 1'b1;
    tick();
    bus_a.out_ready = 1'b0;
  endtask

  task automatic finish_b();
    bus_b.out_ready = 1'b1;
    tick();
    bus_b.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    n_checks++;
    if (bus_a.out_valid !== 1'b0 || busy_a !== 1'b0 || bus_a.out_vec !== '0) begin
      n_fails++;
      $display("FAIL reset_a: out_valid=%b busy=%b out_vec=%h, required 0/0/0",
               bus_a.out_valid, busy_a, bus_a.out_vec);
    end
    n_checks++;
    if (bus_b.out_valid !== 1'b0 || busy_b !== 1'b0 || bus_b.out_vec !== '0) begin
      n_fails++;
      $display("FAIL reset_b: out_valid=%b busy=%b out_vec=%h, required 0/0/0",
               bus_b.out_valid, busy_b, bus_b.out_vec);
    end
    rst = 1'b0;
    tick();
    n_checks++;
    if (bus_a.in_ready !== 1'b1 || bus_b.in_ready !== 1'b1) begin
      n_fails++;
      $display("FAIL reset_ready: in_ready a=%b b=%b, required 1/1",
               bus_a.in_ready, bus_b.in_ready);
    end
    ms_a = SeedDefault;
    ms_b = SeedDefault;
  endtask

  task automatic test_single_flip();
    logic [255:0] exp, onehot;
    int lat, cyc;
    seed_a(16'hACE1);
    start_a('0, 1, lat);
    model_run(256, 8, ms_a, '0, 1, exp, cyc);
    onehot = '0;
    onehot[8'hE1] = 1'b1;
    n_checks++;
    if (bus_a.out_vec !== onehot) begin
      n_fails++;
      $display("FAIL single_flip_vec: got %h, required %h", bus_a.out_vec, onehot);
    end
    n_checks++;
    if (lat !== 2 || cyc !== 2) begin
      n_fails++;
      $display("FAIL single_flip_lat: got %0d, required 2", lat);
    end
    finish_a();
  endtask

  task automatic test_zero_count();
    logic [255:0] exp, ones;
    int lat, cyc;
    ones = '1;
    start_a(ones, 0, lat);
    model_run(256, 8, ms_a, ones, 0, exp, cyc);
    n_checks++;
    if (bus_a.out_vec !== ones) begin
      n_fails++;
      $display("FAIL zero_count_vec: got %h, required all ones", bus_a.out_vec);
    end
    n_checks++;
    if (lat !== 1) begin
      n_fails++;
      $display("FAIL zero_count_lat: got %0d, required 1", lat);
    end
    finish_a();
    // A following single flip reveals whether the LFSR moved during the zero count.
    start_a('0, 1, lat);
    model_run(256, 8, ms_a, '0, 1, exp, cyc);
    n_checks++;
    if (bus_a.out_vec !== exp) begin
      n_fails++;
      $display("FAIL zero_count_lfsr: got %h, required %h", bus_a.out_vec, exp);
    end
    finish_a();
  endtask

  task automatic test_rejection();
    logic [255:0] exp;
    int lat, cyc;
    seed_b(16'h0001);
    start_b('0, 64, lat);
    model_run(200, 8, ms_b, '0, 64, exp, cyc);
    n_checks++;
    if (bus_b.out_vec !== exp[199:0]) begin
      n_fails++;
      $display("FAIL rejection_vec: got %h, required %h", bus_b.out_vec, exp[199:0]);
    end
    n_checks++;
    if (lat !== cyc) begin
      n_fails++;
      $display("FAIL rejection_lat: got %0d, required %0d (rejected %0d)",
               lat, cyc, cyc - 65);
    end
`ifdef HV_FLIP_MASK_EN
    n_checks++;
    if (flip_mask_b !== exp[199:0]) begin
      n_fails++;
      $display("FAIL rejection_mask: got %h, required %h", flip_mask_b, exp[199:0]);
    end
`endif
    finish_b();
  endtask

  task automatic test_done_hold();
    logic [255:0] v, exp;
    int lat, cyc;
    v = rand256();
    start_a(v, 3, lat);
    model_run(256, 8, ms_a, v, 3, exp, cyc);
    n_checks++;
    if (lat !== cyc) begin
      n_fails++;
      $display("FAIL hold_lat: got %0d, required %0d", lat, cyc);
    end
    for (int i = 0; i < 10; i++) begin
      bus_a.in_valid = 1'b1;
      bus_a.in_vec   = ~v;
      bus_a.flip_count = 12'd7;
      seed_load_a = 1'b1;
      seed_in_a   = 16'($urandom);
      tick();
      n_checks++;
      if (bus_a.out_vec !== exp || bus_a.out_valid !== 1'b1 || bus_a.in_ready !== 1'b0) begin
        n_fails++;
        $display("FAIL hold_cycle%0d: out_vec=%h valid=%b in_ready=%b, required %h/1/0",
                 i, bus_a.out_vec, bus_a.out_valid, bus_a.in_ready, exp);
      end
    end
    bus_a.in_valid = 1'b0;
    seed_load_a    = 1'b0;
    finish_a();
    n_checks++;
    if (bus_a.out_valid !== 1'b0 || busy_a !== 1'b0) begin
      n_fails++;
      $display("FAIL hold_release: valid=%b busy=%b, required 0/0", bus_a.out_valid, busy_a);
    end
    v = rand256();
    start_a(v, 4, lat);
    model_run(256, 8, ms_a, v, 4, exp, cyc);
    n_checks++;
    if (bus_a.out_vec !== exp || lat !== cyc) begin
      n_fails++;
      $display("FAIL hold_resume: got %h lat %0d, required %h lat %0d",
               bus_a.out_vec, lat, exp, cyc);
    end
    finish_a();
  endtask

  task automatic test_reset_mid_flip();
    logic [255:0] exp, onehot;
    int lat, cyc;
    bit seen;
    bus_a.in_vec     = rand256();
    bus_a.flip_count = 12'd20;
    bus_a.in_valid   = 1'b1;
    tick();
    bus_a.in_valid = 1'b0;
    repeat (4) tick();
    n_checks++;
    if (busy_a !== 1'b1) begin
      n_fails++;
      $display("FAIL midflip_busy: got %b, required 1", busy_a);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    ms_a = SeedDefault;
    ms_b = SeedDefault;
    n_checks++;
    if (bus_a.out_valid !== 1'b0 || bus_a.out_vec !== '0 || busy_a !== 1'b0
        || bus_a.in_ready !== 1'b1) begin
      n_fails++;
      $display("FAIL midflip_abort: valid=%b vec=%h busy=%b ready=%b, required 0/0/0/1",
               bus_a.out_valid, bus_a.out_vec, busy_a, bus_a.in_ready);
    end
    seen = 1'b0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (bus_a.out_valid === 1'b1) seen = 1'b1;
    end
    n_checks++;
    if (seen !== 1'b0) begin
      n_fails++;
      $display("FAIL midflip_no_output: out_valid seen=%b, required 0", seen);
    end
    start_a('0, 1, lat);
    model_run(256, 8, ms_a, '0, 1, exp, cyc);
    onehot = '0;
    onehot[8'hE1] = 1'b1;
    n_checks++;
    if (bus_a.out_vec !== onehot || lat !== 2) begin
      n_fails++;
      $display("FAIL midflip_lfsr_default: got %h lat %0d, required %h lat 2",
               bus_a.out_vec, lat, onehot);
    end
    finish_a();
  endtask

  task automatic test_seed_zero_with_valid();
    logic [255:0] v, exp;
    int lat, cyc;
    seed_a(16'h1234);
    v = rand256();
    seed_load_a      = 1'b1;
    seed_in_a        = 16'h0000;
    bus_a.in_valid   = 1'b1;
    bus_a.in_vec     = v;
    bus_a.flip_count = 12'd5;
    #1;
    n_checks++;
    if (bus_a.in_ready !== 1'b0) begin
      n_fails++;
      $display("FAIL seed0_ready: got %b, required 0", bus_a.in_ready);
    end
    tick();
    ms_a = SeedDefault;
    seed_load_a = 1'b0;
    n_checks++;
    if (busy_a !== 1'b0) begin
      n_fails++;
      $display("FAIL seed0_not_accepted: busy=%b, required 0", busy_a);
    end
    start_a(v, 5, lat);
    model_run(256, 8, ms_a, v, 5, exp, cyc);
    n_checks++;
    if (bus_a.out_vec !== exp || lat !== cyc) begin
      n_fails++;
      $display("FAIL seed0_accept: got %h lat %0d, required %h lat %0d",
               bus_a.out_vec, lat, exp, cyc);
    end
`ifdef HV_FLIP_MASK_EN
    n_checks++;
    if (flip_mask_a !== (v ^ exp)) begin
      n_fails++;
      $display("FAIL seed0_mask: got %h, required %h", flip_mask_a, v ^ exp);
    end
`endif
    finish_a();
  endtask

  task automatic test_random();
    logic [255:0] v, exp;
    logic [15:0]  sd;
    int lat, cyc, n;
    for (int it = 0; it < 12; it++) begin
      if ($urandom_range(0, 3) == 0) begin
        sd = ($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom);
        seed_a(sd);
        seed_b(~sd);
      end
      v = rand256();
      n = int'($urandom_range(0, 40));
      start_a(v, n, lat);
      model_run(256, 8, ms_a, v, n, exp, cyc);
      n_checks++;
      if (bus_a.out_vec !== exp || lat !== cyc) begin
        n_fails++;
        $display("FAIL random_a%0d: got %h lat %0d, required %h lat %0d",
                 it, bus_a.out_vec, lat, exp, cyc);
      end
`ifdef HV_FLIP_MASK_EN
      n_checks++;
      if (flip_mask_a !== (v ^ exp)) begin
        n_fails++;
        $display("FAIL random_mask_a%0d: got %h, required %h", it, flip_mask_a, v ^ exp);
      end
`endif
      finish_a();
      v = rand256();
      n = int'($urandom_range(0, 40));
      start_b(v[199:0], n, lat);
      model_run(200, 8, ms_b, {56'h0, v[199:0]}, n, exp, cyc);
      n_checks++;
      if (bus_b.out_vec !== exp[199:0] || lat !== cyc) begin
        n_fails++;
        $display("FAIL random_b%0d: got %h lat %0d, required %h lat %0d",
                 it, bus_b.out_vec, lat, exp[199:0], cyc);
      end
      finish_b();
    end
  endtask

  initial begin
    bus_a.in_valid   = 1'b0;
    bus_a.in_vec     = '0;
    bus_a.flip_count = '0;
    bus_a.out_ready  = 1'b0;
    bus_b.in_valid   = 1'b0;
    bus_b.in_vec     = '0;
    bus_b.flip_count = '0;
    bus_b.out_ready  = 1'b0;

    test_reset();
    test_single_flip();
    test_zero_count();
    test_rejection();
    test_done_hold();
    test_reset_mid_flip();
    test_seed_zero_with_valid();
    test_random();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
